// File: rtl/scarv_soc_periph_bridge_pkg.sv
// Shared types and constants for the SoC peripheral bridge and peripheral top.
// Package scarv_soc_periph_pkg: bridge state enum, window size, defaults.
package scarv_soc_periph_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } bridge_state_t;

    localparam int          PERIPH_WINDOW_BITS = 16;
    localparam logic [31:0] PERIPH_BASE_DEF    = 32'h1000_0000;
    localparam int          TIMEOUT_CYCLES_DEF = 256;

    // True when addr falls in the 64KB window starting at base.
    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr[31:PERIPH_WINDOW_BITS] == base[31:PERIPH_WINDOW_BITS];
    endfunction

endpackage

// File: rtl/scarv_soc_periph_bridge_if.sv
// CCX memory interface: request channel (req/gnt) and response (recv/ack).
// REQ modport is the initiator, RSP modport is the target.
interface scarv_ccx_memif #(
    parameter int AW = 32
);
    logic          req;
    logic          gnt;
    logic          wen;
    logic [3:0]    strb;
    logic [31:0]   wdata;
    logic [AW-1:0] addr;
    logic          recv;
    logic          ack;
    logic          error;
    logic [31:0]   rdata;

    modport REQ (
        output req, wen, strb, wdata, addr, ack,
        input  gnt, recv, error, rdata
    );

    modport RSP (
        input  req, wen, strb, wdata, addr, ack,
        output gnt, recv, error, rdata
    );

endinterface

// File: rtl/scarv_soc_periph_bridge.sv
// Single-outstanding registered bridge from the CPU memif to the peripherals.
// Optional hung-transaction timeout: SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN.
module scarv_soc_periph_bridge
    import scarv_soc_periph_pkg::*;
#(
    parameter logic [31:0] PERIPH_BASE    = PERIPH_BASE_DEF,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int          TW             = 9
) (
    input  logic           g_clk,
    input  logic           g_resetn,
    output logic           g_clk_req,
    scarv_ccx_memif.RSP    memif_cpu,
    scarv_ccx_memif.REQ    memif_periph
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES >= (1 << TW)) ||
        (PERIPH_BASE[15:0] != 16'h0)) begin : g_bad_cfg
        $error("scarv_soc_periph_bridge: bad parameter set");
    end

    bridge_state_t state_q;
    bridge_state_t state_d;

    logic        gnt_q;
    logic        recv_q;
    logic        preq_q;
    logic        pack_q;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  strb_q;
    logic        wen_q;
    logic        err_q;

    logic        stale_q;
    logic        stale_d;

    logic        cpu_xfer;
    logic        cpu_done;
    logic        per_xfer;
    logic        per_done;
    logic        hit;
    logic        timeout;
    logic        to_fire;

    // Handshake detection against the registered side of each channel.
    always_comb begin
        cpu_xfer = memif_cpu.req && gnt_q;
        cpu_done = recv_q && memif_cpu.ack;
        per_xfer = preq_q && memif_periph.gnt;
        per_done = pack_q && memif_periph.recv;
        hit      = in_window(memif_cpu.addr, PERIPH_BASE);
    end

    // Next-state logic; a completing handshake beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        to_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_xfer) begin
                    state_d = hit ? FWD : RESP;
                end
            end
            FWD: begin
                if (per_xfer) begin
                    state_d = WAIT;
                end else if (timeout) begin
                    state_d = RESP;
                    to_fire = 1'b1;
                end
            end
            WAIT: begin
                if (per_done) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                    to_fire = 1'b1;
                end
            end
            RESP: begin
                if (cpu_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q;

    assign timeout = ((state_q == FWD) || (state_q == WAIT)) &&
                     (cnt_q == CNT_LAST);

    // Cycle counter covering the time spent in FWD and WAIT.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && (state_d == FWD)) begin
            cnt_q <= '0;
        end else if ((state_q == FWD) || (state_q == WAIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A WAIT timeout leaves one response owed; it is swallowed later.
    always_comb begin
        stale_d = stale_q;
        if ((state_q == WAIT) && to_fire) begin
            stale_d = 1'b1;
        end else if (stale_q && per_done) begin
            stale_d = 1'b0;
        end
    end

    // Stale flag register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            stale_q <= 1'b0;
        end else begin
            stale_q <= stale_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign stale_d = 1'b0;
    assign stale_q = 1'b0;
`endif

    // State register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs are flops decoded from the next state.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            gnt_q  <= 1'b0;
            preq_q <= 1'b0;
            pack_q <= 1'b0;
            recv_q <= 1'b0;
        end else begin
            gnt_q  <= (state_d == IDLE) && !stale_d;
            preq_q <= (state_d == FWD);
            pack_q <= (state_d == WAIT) || stale_d;
            recv_q <= (state_d == RESP);
        end
    end

    // Request capture and response capture registers.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (cpu_xfer) begin
            addr_q  <= memif_cpu.addr;
            wdata_q <= memif_cpu.wdata;
            strb_q  <= memif_cpu.strb;
            wen_q   <= memif_cpu.wen;
            rdata_q <= '0;
            err_q   <= !hit;
        end else if ((state_q == WAIT) && per_done) begin
            rdata_q <= memif_periph.rdata;
            err_q   <= memif_periph.error;
        end else if (to_fire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    assign memif_cpu.gnt      = gnt_q;
    assign memif_cpu.recv     = recv_q;
    assign memif_cpu.error    = err_q;
    assign memif_cpu.rdata    = rdata_q;

    assign memif_periph.req   = preq_q;
    assign memif_periph.addr  = addr_q;
    assign memif_periph.wdata = wdata_q;
    assign memif_periph.strb  = strb_q;
    assign memif_periph.wen   = wen_q;
    assign memif_periph.ack   = pack_q;

    assign g_clk_req = (state_q != IDLE) || memif_cpu.req || stale_q;

endmodule

// File: tb/tb_scarv_soc_periph_bridge.sv
// Directed plus randomized bench for scarv_soc_periph_bridge.
// Timeout steps run only when SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN is defined.
module tb_scarv_soc_periph_bridge;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 256;
`endif

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic g_clk_req;

  int tests = 0;
  int fails = 0;

  scarv_ccx_memif #(.AW(32)) cpu_if ();
  scarv_ccx_memif #(.AW(32)) per_if ();

  scarv_soc_periph_bridge #(
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .g_clk_req    (g_clk_req),
    .memif_cpu    (cpu_if),
    .memif_periph (per_if)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(
    input  logic [31:0] a,
    input  logic        pe,
    input  logic [31:0] prd,
    output logic        fwd,
    output logic        ee,
    output logic [31:0] er
  );
    fwd = (a / 32'd65536) == (BASE / 32'd65536);
    ee  = fwd ? pe : 1'b1;
    er  = fwd ? prd : 32'h0;
  endfunction

  task automatic do_txn(
    input logic [31:0] a, input logic w, input logic [3:0] s,
    input logic [31:0] wd, input int gd, input int rd, input int ad,
    input logic pe, input logic [31:0] prd
  );
    logic fwd, ee;
    logic [31:0] er;
    model(a, pe, prd, fwd, ee, er);
    cpu_if.req = 1'b1;
    cpu_if.addr = a;
    cpu_if.wen = w;
    cpu_if.strb = s;
    cpu_if.wdata = wd;
    #1;
    chk("cpu_gnt_idle", cpu_if.gnt, 1'b1);
    chk("clk_req_on_req", g_clk_req, 1'b1);
    @(negedge g_clk);
    cpu_if.req = 1'b0;
    cpu_if.addr = $urandom;
    cpu_if.wdata = $urandom;
    cpu_if.strb = 4'($urandom);
    if (fwd) begin
      for (int i = 0; i <= gd; i++) begin
        chk("per_req", per_if.req, 1'b1);
        chk("per_addr", per_if.addr, a);
        chk("per_wdata", per_if.wdata, wd);
        chk("per_strb", {28'h0, per_if.strb}, {28'h0, s});
        chk("per_wen", per_if.wen, w);
        chk("cpu_recv_fwd", cpu_if.recv, 1'b0);
        if (i == gd) per_if.gnt = 1'b1;
        @(negedge g_clk);
      end
      per_if.gnt = 1'b0;
      chk("per_req_drop", per_if.req, 1'b0);
      for (int i = 0; i < rd; i++) begin
        chk("per_ack_wait", per_if.ack, 1'b1);
        chk("cpu_recv_wait", cpu_if.recv, 1'b0);
        @(negedge g_clk);
      end
      chk("per_ack", per_if.ack, 1'b1);
      per_if.recv = 1'b1;
      per_if.error = pe;
      per_if.rdata = prd;
      @(negedge g_clk);
      per_if.recv = 1'b0;
      per_if.error = $urandom;
      per_if.rdata = $urandom;
      chk("per_ack_drop", per_if.ack, 1'b0);
    end else begin
      chk("per_req_blocked", per_if.req, 1'b0);
    end
    for (int i = 0; i <= ad; i++) begin
      chk("cpu_recv", cpu_if.recv, 1'b1);
      chk("cpu_error", cpu_if.error, ee);
      if (!(fwd && w)) chk("cpu_rdata", cpu_if.rdata, er);
      chk("cpu_gnt_resp", cpu_if.gnt, 1'b0);
      if (i == ad) cpu_if.ack = 1'b1;
      @(negedge g_clk);
    end
    cpu_if.ack = 1'b0;
    chk("cpu_recv_drop", cpu_if.recv, 1'b0);
    chk("cpu_gnt_after", cpu_if.gnt, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int n;
    cpu_if.req = 1'b0;
    cpu_if.addr = '0;
    cpu_if.wen = 1'b0;
    cpu_if.strb = '0;
    cpu_if.wdata = '0;
    cpu_if.ack = 1'b0;
    per_if.gnt = 1'b0;
    per_if.recv = 1'b0;
    per_if.error = 1'b0;
    per_if.rdata = '0;

    #12;
    chk("rst_cpu_gnt", cpu_if.gnt, 1'b0);
    chk("rst_cpu_recv", cpu_if.recv, 1'b0);
    chk("rst_per_req", per_if.req, 1'b0);
    chk("rst_per_ack", per_if.ack, 1'b0);
    chk("rst_clk_req", g_clk_req, 1'b0);
    chk("rst_rdata", cpu_if.rdata, 32'h0);
    chk("rst_error", cpu_if.error, 1'b0);
    chk("rst_addr", per_if.addr, 32'h0);
    chk("rst_wdata", per_if.wdata, 32'h0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    @(negedge g_clk);
    chk("idle_clk_req", g_clk_req, 1'b0);

    do_txn(32'h1000_1004, 1'b0, 4'hf, 32'h0, 0, 0, 0,
           1'b0, 32'hCAFE_0001);
    do_txn(32'h1000_0000, 1'b1, 4'b0001, 32'h55, 0, 0, 0,
           1'b0, 32'h0);
    do_txn(32'h2000_0000, 1'b0, 4'hf, 32'h0, 0, 0, 0,
           1'b0, 32'h1234_5678);
    do_txn(32'h1000_ABC0, 1'b0, 4'hf, 32'h0, 5, 1, 3,
           1'b1, 32'hDEAD_BEEF);

    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      if ($urandom_range(1, 0) == 1) a = BASE | {16'h0, a[15:0]};
      do_txn(a, 1'($urandom), 4'($urandom), $urandom,
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
             int'($urandom_range(3, 0)), 1'($urandom), $urandom);
    end

`ifdef SCARV_SOC_PERIPH_BRIDGE_TIMEOUT_EN
    cpu_if.req = 1'b1;
    cpu_if.addr = 32'h1000_0008;
    cpu_if.wen = 1'b0;
    @(negedge g_clk);
    cpu_if.req = 1'b0;
    chk("to_per_req", per_if.req, 1'b1);
    per_if.gnt = 1'b1;
    @(negedge g_clk);
    per_if.gnt = 1'b0;
    chk("to_per_ack", per_if.ack, 1'b1);
    n = 0;
    while (!cpu_if.recv && n < 30) begin
      @(negedge g_clk);
      n++;
    end
    chk("to_latency", n, 7);
    chk("to_error", cpu_if.error, 1'b1);
    chk("to_rdata", cpu_if.rdata, 32'h0);
    cpu_if.ack = 1'b1;
    @(negedge g_clk);
    cpu_if.ack = 1'b0;
    chk("stale_gnt", cpu_if.gnt, 1'b0);
    chk("stale_ack", per_if.ack, 1'b1);
    chk("stale_clk_req", g_clk_req, 1'b1);
    cpu_if.req = 1'b1;
    cpu_if.addr = 32'h1000_0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      chk("stale_stall", cpu_if.gnt, 1'b0);
    end
    per_if.recv = 1'b1;
    per_if.rdata = 32'h0BAD_0BAD;
    @(negedge g_clk);
    per_if.recv = 1'b0;
    chk("swallow_recv", cpu_if.recv, 1'b0);
    chk("swallow_ack", per_if.ack, 1'b0);
    chk("swallow_gnt", cpu_if.gnt, 1'b1);
    cpu_if.req = 1'b0;
    do_txn(32'h1000_0010, 1'b0, 4'hf, 32'h0, 1, 0, 0,
           1'b0, 32'h7777_0000);
`endif

    cpu_if.req = 1'b1;
    cpu_if.addr = 32'h1000_2000;
    cpu_if.wen = 1'b0;
    @(negedge g_clk);
    cpu_if.req = 1'b0;
    per_if.gnt = 1'b1;
    @(negedge g_clk);
    per_if.gnt = 1'b0;
    chk("rst_pre_ack", per_if.ack, 1'b1);
    #2;
    g_resetn = 1'b0;
    #1;
    chk("arst_per_ack", per_if.ack, 1'b0);
    chk("arst_per_req", per_if.req, 1'b0);
    chk("arst_cpu_recv", cpu_if.recv, 1'b0);
    chk("arst_cpu_gnt", cpu_if.gnt, 1'b0);
    chk("arst_clk_req", g_clk_req, 1'b0);
    chk("arst_addr", per_if.addr, 32'h0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    @(negedge g_clk);
    @(negedge g_clk);
    do_txn(32'h1000_3000, 1'b0, 4'hf, 32'h0, 0, 0, 0,
           1'b0, 32'hA5A5_5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
